// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver:
// hex->segment table (active-low), blank pattern, index-width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry k is the active-low {g,f,e,d,c,b,a} pattern for nibble k.
  localparam logic [0:15][6:0] SEG_HEX = {
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h27, 7'h21, 7'h06, 7'h0E
  };

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment decode.
// Ports: nibble (4b in), seg (7b out, {g,f,e,d,c,b,a}).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit common-anode scanner: dp, blank, lz suppress, PWM, dead time.
// Ports: clk/rst_n, value/dp/blank/lz/load in, brightness, seg/dp/sel out.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int SLOT_LOG2   = 15,
  parameter int DEAD_CYCLES = 16,
  parameter int BRIGHT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  lz_en,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  load_ack,
  output logic                  frame_done,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   sel_n
);

  localparam int IW = idx_w(N_DIGITS);
  localparam logic [IW-1:0] LAST_IDX =
    IW'(N_DIGITS - 1);
  localparam logic [SLOT_LOG2-1:0] DEAD =
    SLOT_LOG2'(DEAD_CYCLES);

  logic [SLOT_LOG2-1:0]  cnt;
  logic [IW-1:0]         idx;
  logic [BRIGHT_W-1:0]   bri_q;
  logic [BRIGHT_W-1:0]   bri_eff;

  logic [4*N_DIGITS-1:0] val_a, val_p;
  logic [N_DIGITS-1:0]   dp_a, dp_p;
  logic [N_DIGITS-1:0]   blank_a, blank_p;
  logic                  lz_a, lz_p;
  logic                  pend_v;

  logic                  cnt_max;
  logic                  commit;
  logic                  lit;
  logic [N_DIGITS-1:0]   supp;
  logic                  seen;
  logic [3:0]            nibble;
  logic [6:0]            dec;
  logic                  dark;

  assign cnt_max    = &cnt;
  assign frame_done = cnt_max && (idx == LAST_IDX);
  // pend_v is the registered flag, so a load in this
  // very cycle waits for the next frame boundary.
  assign commit     = frame_done && pend_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt_max)
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bri_q <= '0;
    else if (cnt == '0)
      bri_q <= brightness;
  end

  // At cnt=0 the latch is being loaded; use the live value.
  assign bri_eff = (cnt == '0) ? brightness : bri_q;

  assign lit = (cnt >= DEAD) &&
    (cnt[SLOT_LOG2-1 -: BRIGHT_W] <= bri_eff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_p   <= '0;
      dp_p    <= '0;
      blank_p <= '0;
      lz_p    <= 1'b0;
      pend_v  <= 1'b0;
    end else begin
      if (load) begin
        val_p   <= value_in;
        dp_p    <= dp_in;
        blank_p <= blank_in;
        lz_p    <= lz_en;
        pend_v  <= 1'b1;
      end else if (commit) begin
        pend_v  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_a   <= '0;
      dp_a    <= '0;
      blank_a <= '1;
      lz_a    <= 1'b0;
    end else if (commit) begin
      val_a   <= val_p;
      dp_a    <= dp_p;
      blank_a <= blank_p;
      lz_a    <= lz_p;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      load_ack <= 1'b0;
    else
      load_ack <= commit;
  end

  // Walk from the top digit down; digit 0 is never suppressed.
  always_comb begin
    supp = '0;
    seen = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      seen    = seen | (val_a[4*i +: 4] != 4'h0);
      supp[i] = lz_a & ~seen;
    end
  end

  assign nibble = val_a[4*idx +: 4];
  assign dark   = blank_a[idx] | supp[idx];

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_n <= '1;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else if (lit) begin
      sel_n <= ~(N_DIGITS'(1) << idx);
      seg_n <= dark ? SEG_OFF : dec;
      dp_n  <= blank_a[idx] | ~dp_a[idx];
    end else begin
      sel_n <= '1;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (4 digits, 64-cycle slots).
// Stimulus queues expected lit runs and acks; a monitor checks them.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int SL = 6;
  localparam int DC = 4;
  localparam int BW = 2;

  logic          clk;
  logic          rst_n;
  logic [4*N-1:0] value_in;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank_in;
  logic          lz_en;
  logic          load;
  logic [BW-1:0] brightness;
  logic          load_ack;
  logic          frame_done;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [N-1:0]  sel_n;

  seg7_scan_driver #(
    .N_DIGITS    (N),
    .SLOT_LOG2   (SL),
    .DEAD_CYCLES (DC),
    .BRIGHT_W    (BW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load       (load),
    .brightness (brightness),
    .load_ack   (load_ack),
    .frame_done (frame_done),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .sel_n      (sel_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } rec_t;

  rec_t exp_q[$];
  int   ack_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  // Monitor: one record per contiguous lit run.
  logic in_run = 1'b0;
  logic stable;
  rec_t cur;
  rec_t e;
  int   last_fd = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_run  = 1'b0;
      last_fd = -1;
    end else begin
      if (load_ack) begin
        if (ack_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected load_ack: cycle %0d",
                   cyc);
        end else begin
          check("load_ack cycle", cyc, ack_q.pop_front());
        end
      end
      if (frame_done) begin
        if (last_fd >= 0)
          check("frame period", cyc - last_fd, 256);
        last_fd = cyc;
      end
      if (sel_n != 4'hF) begin
        if (!in_run) begin
          in_run  = 1'b1;
          cur.sel = sel_n;
          cur.seg = seg_n;
          cur.dp  = dp_n;
          cur.len = 1;
          stable  = 1'b1;
        end else begin
          cur.len++;
          if (sel_n != cur.sel || seg_n != cur.seg ||
              dp_n != cur.dp)
            stable = 1'b0;
        end
      end else if (in_run) begin
        in_run = 1'b0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("run sel_n", 32'(cur.sel), 32'(e.sel));
          check("run seg_n", 32'(cur.seg), 32'(e.seg));
          check("run dp_n", 32'(cur.dp), 32'(e.dp));
          check("run length", cur.len, e.len);
          check("run stable", 32'(stable), 32'd1);
        end
      end
    end
  end

  task automatic wait_fd();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL frame_done timeout: cycle %0d", cyc);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0,
                            input logic [6:0] s1,
                            input logic [6:0] s2,
                            input logic [6:0] s3,
                            input logic [3:0] dpn,
                            input int len);
    exp_q.push_back('{4'b1110, s0, dpn[0], len});
    exp_q.push_back('{4'b1101, s1, dpn[1], len});
    exp_q.push_back('{4'b1011, s2, dpn[2], len});
    exp_q.push_back('{4'b0111, s3, dpn[3], len});
  endtask

  task automatic do_load(input logic [15:0] v,
                         input logic [3:0] d,
                         input logic [3:0] b,
                         input logic z);
    @(negedge clk);
    value_in = v;
    dp_in    = d;
    blank_in = b;
    lz_en    = z;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  // At a frame_done negedge: expect ack, then queue next frame.
  task automatic commit_frame(input logic [6:0] s0,
                              input logic [6:0] s1,
                              input logic [6:0] s2,
                              input logic [6:0] s3,
                              input logic [3:0] dpn);
    wait_fd();
    ack_q.push_back(cyc + 1);
    repeat (3) @(negedge clk);
    push_frame(s0, s1, s2, s3, dpn, 60);
  endtask

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    value_in   = '0;
    dp_in      = '0;
    blank_in   = '0;
    lz_en      = 1'b0;
    brightness = 2'd3;
    repeat (3) @(negedge clk);
    check("reset sel_n", 32'(sel_n), 32'hF);
    check("reset seg_n", 32'(seg_n), 32'h7F);
    check("reset dp_n", 32'(dp_n), 32'd1);
    check("reset load_ack", 32'(load_ack), 32'd0);
    check("reset frame_done", 32'(frame_done), 32'd0);

    // Dark display, normal strobing, no ack.
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 60);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 60);
    rst_n = 1'b1;
    wait_fd();
    wait_fd();

    do_load(16'h12AC, 4'h0, 4'h0, 1'b0);
    commit_frame(7'h27, 7'h08, 7'h24, 7'h79, 4'hF);

    wait_fd();
    brightness = 2'd0;
    repeat (3) @(negedge clk);
    push_frame(7'h27, 7'h08, 7'h24, 7'h79, 4'hF, 12);
    wait_fd();
    brightness = 2'd1;
    repeat (3) @(negedge clk);
    push_frame(7'h27, 7'h08, 7'h24, 7'h79, 4'hF, 28);
    wait_fd();
    brightness = 2'd3;

    do_load(16'h0030, 4'b0100, 4'h0, 1'b1);
    commit_frame(7'h40, 7'h30, 7'h7F, 7'h7F, 4'b1011);

    do_load(16'h0000, 4'h0, 4'h0, 1'b1);
    commit_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'hF);

    do_load(16'h1234, 4'b0010, 4'b0010, 1'b0);
    commit_frame(7'h19, 7'h7F, 7'h24, 7'h79, 4'hF);

    // Last of two loads wins, single ack.
    do_load(16'h1111, 4'h0, 4'h0, 1'b0);
    do_load(16'h2222, 4'h0, 4'h0, 1'b0);
    commit_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'hF);

    // Load on the frame_done cycle waits one frame.
    wait_fd();
    value_in = 16'h3333;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    repeat (2) @(negedge clk);
    push_frame(7'h24, 7'h24, 7'h24, 7'h24, 4'hF, 60);
    commit_frame(7'h30, 7'h30, 7'h30, 7'h30, 4'hF);

    // Reset while lit, with a load still pending.
    wait_fd();
    repeat (10) @(negedge clk);
    check("lit before reset", 32'(sel_n), 32'hE);
    value_in = 16'h8888;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst sel_n", 32'(sel_n), 32'hF);
    check("async rst seg_n", 32'(seg_n), 32'h7F);
    check("async rst dp_n", 32'(dp_n), 32'd1);
    repeat (3) @(negedge clk);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 60);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'hF, 60);
    rst_n = 1'b1;
    wait_fd();
    wait_fd();

    begin
      int n = 0;
      while ((exp_q.size() != 0 || ack_q.size() != 0) &&
             n < 600) begin
        @(negedge clk);
        n++;
      end
    end
    check("runs left over", exp_q.size(), 0);
    check("acks left over", ack_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
